// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the two-master Avalon-style bus arbiter.
// Holds bus widths, the grant FSM state enum and the one-hot grant codes.
package mips_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/mips_bus_arbiter_if.sv
// Avalon-style memory bus bundle: address/read/write/writedata/byteenable
// from the requester, readdata/waitrequest back. master = requester side.
interface mips_bus_arbiter_if;
    import mips_bus_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest
    );

endinterface

// File: rtl/mips_bus_arbiter.sv
// Two-master to one-slave bus arbiter with registered grant FSM and stall
// watchdog. Ports: clk, rst (async active-low), m0/m1 (requester buses,
// slave modport), s (RAM bus, master modport), grant (one-hot), timeout.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    mips_bus_arbiter_if.slave        m0,
    mips_bus_arbiter_if.slave        m1,
    mips_bus_arbiter_if.master       s,
    output logic [1:0]               grant,
    output logic                     timeout
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            to_q, to_d;

    logic req0, req1, done, stall;

    assign req0  = m0.read | m0.write;
    assign req1  = m1.read | m1.write;
    assign done  = (s.read | s.write) & ~s.waitrequest;
    assign stall = (state_q != IDLE) & s.waitrequest;

    // Next-state: last_q = 1 means m1 was served last, so m0 wins a tie.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    if (PRIORITY_MODE == 1 || !last_q)
                        state_d = G1;
                    else
                        state_d = G0;
                end else if (req0) begin
                    state_d = G0;
                end else if (req1) begin
                    state_d = G1;
                end
            end
            G0: begin
                if (done) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end else if (!req0) begin
                    state_d = IDLE;
                end
            end
            G1: begin
                if (done) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end else if (!req1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stall counter saturates so a long hang cannot wrap and re-arm.
    always_comb begin
        cnt_d = '0;
        if (stall)
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + TO_W'(1);
        to_d = to_q;
        if (TIMEOUT_CYCLES != 0 && stall && cnt_d >= TO_LIM)
            to_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    // Bus mux driven from registered state only, so reset clears s_* at once.
    always_comb begin
        s.address      = '0;
        s.read         = 1'b0;
        s.write        = 1'b0;
        s.writedata    = '0;
        s.byteenable   = '0;
        m0.waitrequest = req0;
        m1.waitrequest = req1;
        unique case (state_q)
            G0: begin
                s.address      = m0.address;
                s.read         = m0.read;
                s.write        = m0.write;
                s.writedata    = m0.writedata;
                s.byteenable   = m0.byteenable;
                m0.waitrequest = s.waitrequest;
            end
            G1: begin
                s.address      = m1.address;
                s.read         = m1.read;
                s.write        = m1.write;
                s.writedata    = m1.writedata;
                s.byteenable   = m1.byteenable;
                m1.waitrequest = s.waitrequest;
            end
            default: ;
        endcase
    end

    assign m0.readdata = s.readdata;
    assign m1.readdata = s.readdata;

    always_comb begin
        grant = GNT_NONE;
        unique case (state_q)
            G0:      grant = GNT_M0;
            G1:      grant = GNT_M1;
            default: grant = GNT_NONE;
        endcase
    end

    assign timeout = to_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: a round-robin and a fixed-priority
// instance share the same master/slave stimulus.
module tb_mips_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd, s_rdata;
    logic        m0_rd, m0_wr, m1_rd, m1_wr, s_wait;
    logic [3:0]  m0_be, m1_be;

    logic [1:0] a_grant, b_grant;
    logic       a_timeout, b_timeout;

    int errors = 0;
    int checks = 0;

    mips_bus_arbiter_if a_m0();
    mips_bus_arbiter_if a_m1();
    mips_bus_arbiter_if a_s();
    mips_bus_arbiter_if b_m0();
    mips_bus_arbiter_if b_m1();
    mips_bus_arbiter_if b_s();

    assign a_m0.address = m0_addr;
    assign a_m0.read = m0_rd;
    assign a_m0.write = m0_wr;
    assign a_m0.writedata = m0_wd;
    assign a_m0.byteenable = m0_be;
    assign a_m1.address = m1_addr;
    assign a_m1.read = m1_rd;
    assign a_m1.write = m1_wr;
    assign a_m1.writedata = m1_wd;
    assign a_m1.byteenable = m1_be;
    assign a_s.readdata = s_rdata;
    assign a_s.waitrequest = s_wait;

    assign b_m0.address = m0_addr;
    assign b_m0.read = m0_rd;
    assign b_m0.write = m0_wr;
    assign b_m0.writedata = m0_wd;
    assign b_m0.byteenable = m0_be;
    assign b_m1.address = m1_addr;
    assign b_m1.read = m1_rd;
    assign b_m1.write = m1_wr;
    assign b_m1.writedata = m1_wd;
    assign b_m1.byteenable = m1_be;
    assign b_s.readdata = s_rdata;
    assign b_s.waitrequest = s_wait;

    mips_bus_arbiter #(
        .PRIORITY_MODE(0),
        .TIMEOUT_CYCLES(5),
        .TO_W(16)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .m0(a_m0.slave),
        .m1(a_m1.slave),
        .s(a_s.master),
        .grant(a_grant),
        .timeout(a_timeout)
    );

    mips_bus_arbiter #(
        .PRIORITY_MODE(1),
        .TIMEOUT_CYCLES(5),
        .TO_W(16)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .m0(b_m0.slave),
        .m1(b_m1.slave),
        .s(b_s.master),
        .grant(b_grant),
        .timeout(b_timeout)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        m0_addr = '0; m0_rd = 0; m0_wr = 0; m0_wd = '0; m0_be = '0;
        m1_addr = '0; m1_rd = 0; m1_wr = 0; m1_wd = '0; m1_be = '0;
        s_rdata = '0; s_wait = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 0;
        step();
        step();
        rst = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        #1;
        checks++;
        if (a_grant !== 2'b00) begin
            errors++;
            $display("FAIL reset_grant_a got %b exp 00", a_grant);
        end
        checks++;
        if (b_grant !== 2'b00) begin
            errors++;
            $display("FAIL reset_grant_b got %b exp 00", b_grant);
        end
        checks++;
        if (a_s.read !== 1'b0 || a_s.write !== 1'b0) begin
            errors++;
            $display("FAIL reset_srw got %b%b exp 00", a_s.read, a_s.write);
        end
        checks++;
        if (a_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_timeout got %b exp 0", a_timeout);
        end
        step();
        step();
        rst = 1;
    endtask

    task automatic test_single_read();
        apply_reset();
        m0_rd = 1;
        m0_addr = 32'hBFC0_0000;
        s_rdata = 32'h3C02_1234;
        s_wait = 0;
        #1;
        checks++;
        if (a_grant !== 2'b00 || a_m0.waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL rd_arb got grant=%b wr=%b exp 00/1",
                     a_grant, a_m0.waitrequest);
        end
        step();
        #1;
        checks++;
        if (a_grant !== 2'b01) begin
            errors++;
            $display("FAIL rd_grant got %b exp 01", a_grant);
        end
        checks++;
        if (a_s.read !== 1'b1 || a_s.address !== 32'hBFC0_0000) begin
            errors++;
            $display("FAIL rd_sbus got rd=%b addr=%h exp 1/bfc00000",
                     a_s.read, a_s.address);
        end
        checks++;
        if (a_m0.waitrequest !== 1'b0 || a_m0.readdata !== 32'h3C02_1234) begin
            errors++;
            $display("FAIL rd_data got wr=%b data=%h exp 0/3c021234",
                     a_m0.waitrequest, a_m0.readdata);
        end
        step();
        m0_rd = 0;
        #1;
        checks++;
        if (a_grant !== 2'b00 || a_s.read !== 1'b0) begin
            errors++;
            $display("FAIL rd_idle got grant=%b rd=%b exp 00/0",
                     a_grant, a_s.read);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] ea [8];
        logic [1:0] eb [8];
        ea = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        eb = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
        apply_reset();
        m0_rd = 1;
        m1_rd = 1;
        m0_addr = 32'h0000_0100;
        m1_addr = 32'h0000_0200;
        s_rdata = 32'h1111_2222;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (a_grant !== ea[i]) begin
                errors++;
                $display("FAIL rr_grant[%0d] got %b exp %b", i, a_grant, ea[i]);
            end
            checks++;
            if (b_grant !== eb[i]) begin
                errors++;
                $display("FAIL fp_grant[%0d] got %b exp %b", i, b_grant, eb[i]);
            end
            step();
        end
    endtask

    task automatic test_fixed_priority();
        apply_reset();
        m0_rd = 1;
        m1_rd = 0;
        s_wait = 0;
        step();
        #1;
        checks++;
        if (b_grant !== 2'b01) begin
            errors++;
            $display("FAIL fp_m0_alone got %b exp 01", b_grant);
        end
        m1_rd = 1;
        step();
        step();
        #1;
        checks++;
        if (b_grant !== 2'b10) begin
            errors++;
            $display("FAIL fp_m1_wins got %b exp 10", b_grant);
        end
        checks++;
        if (b_m0.waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL fp_m0_wait got %b exp 1", b_m0.waitrequest);
        end
    endtask

    task automatic test_slave_stall();
        apply_reset();
        m1_wr = 1;
        m1_wd = 32'hDEAD_BEEF;
        m1_be = 4'b0011;
        m1_addr = 32'h0000_1000;
        m0_rd = 1;
        s_wait = 1;
        #1;
        checks++;
        if (b_grant !== 2'b00 || b_m0.waitrequest !== 1'b1 ||
            b_m1.waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL st_arb got grant=%b w0=%b w1=%b exp 00/1/1",
                     b_grant, b_m0.waitrequest, b_m1.waitrequest);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3)
                s_wait = 0;
            #1;
            checks++;
            if (b_grant !== 2'b10 || b_s.write !== 1'b1 ||
                b_s.writedata !== 32'hDEAD_BEEF ||
                b_s.byteenable !== 4'b0011 ||
                b_s.address !== 32'h0000_1000) begin
                errors++;
                $display("FAIL st_bus[%0d] got g=%b w=%b d=%h be=%b a=%h",
                         i, b_grant, b_s.write, b_s.writedata,
                         b_s.byteenable, b_s.address);
            end
            checks++;
            if (b_m0.waitrequest !== 1'b1 ||
                b_m1.waitrequest !== (i < 3)) begin
                errors++;
                $display("FAIL st_wait[%0d] got w0=%b w1=%b exp 1/%b",
                         i, b_m0.waitrequest, b_m1.waitrequest, (i < 3));
            end
            step();
        end
        m1_wr = 0;
        #1;
        checks++;
        if (b_grant !== 2'b00 || b_timeout !== 1'b0) begin
            errors++;
            $display("FAIL st_done got grant=%b to=%b exp 00/0",
                     b_grant, b_timeout);
        end
        step();
        #1;
        checks++;
        if (b_grant !== 2'b01) begin
            errors++;
            $display("FAIL st_next got %b exp 01", b_grant);
        end
    endtask

    task automatic test_watchdog();
        apply_reset();
        m0_rd = 1;
        m0_addr = 32'h0000_0040;
        s_wait = 1;
        step();
        step();
        step();
        step();
        step();
        #1;
        checks++;
        if (a_timeout !== 1'b0 || a_grant !== 2'b01) begin
            errors++;
            $display("FAIL wd_before got to=%b grant=%b exp 0/01",
                     a_timeout, a_grant);
        end
        step();
        #1;
        checks++;
        if (a_timeout !== 1'b1 || a_grant !== 2'b01) begin
            errors++;
            $display("FAIL wd_fire got to=%b grant=%b exp 1/01",
                     a_timeout, a_grant);
        end
        s_wait = 0;
        step();
        m0_rd = 0;
        step();
        #1;
        checks++;
        if (a_timeout !== 1'b1 || b_timeout !== 1'b1 || a_grant !== 2'b00) begin
            errors++;
            $display("FAIL wd_sticky got a=%b b=%b grant=%b exp 1/1/00",
                     a_timeout, b_timeout, a_grant);
        end
    endtask

    task automatic test_reset_mid();
        m1_wr = 1;
        m1_wd = 32'h0BAD_F00D;
        m1_be = 4'b1111;
        m1_addr = 32'h0000_2000;
        s_wait = 1;
        step();
        step();
        #1;
        checks++;
        if (b_grant !== 2'b10 || a_timeout !== 1'b1) begin
            errors++;
            $display("FAIL rm_pre got grant=%b to=%b exp 10/1",
                     b_grant, a_timeout);
        end
        rst = 0;
        #1;
        checks++;
        if (b_s.write !== 1'b0 || b_s.read !== 1'b0 ||
            b_s.address !== 32'h0) begin
            errors++;
            $display("FAIL rm_sbus got w=%b r=%b a=%h exp 0/0/0",
                     b_s.write, b_s.read, b_s.address);
        end
        checks++;
        if (b_grant !== 2'b00 || a_grant !== 2'b00) begin
            errors++;
            $display("FAIL rm_grant got b=%b a=%b exp 00/00",
                     b_grant, a_grant);
        end
        checks++;
        if (a_timeout !== 1'b0 || b_timeout !== 1'b0) begin
            errors++;
            $display("FAIL rm_timeout got a=%b b=%b exp 0/0",
                     a_timeout, b_timeout);
        end
        idle_inputs();
        step();
        rst = 1;
        m0_rd = 1;
        m1_rd = 1;
        #1;
        checks++;
        if (a_grant !== 2'b00) begin
            errors++;
            $display("FAIL rm_idle got %b exp 00", a_grant);
        end
        step();
        #1;
        checks++;
        if (a_grant !== 2'b01) begin
            errors++;
            $display("FAIL rm_tie got %b exp 01", a_grant);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_priority();
        test_slave_stall();
        test_watchdog();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
